// File: rtl/prbs_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions so that generator and checker
// agree on sequence length, tap positions and checker state encoding.
package prbs_pkg;

  localparam int PRBS31_LEN = 31;
  localparam int TAP_A      = 27;
  localparam int TAP_B      = 30;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Next bit of the sequence predicted from the last 31 bits (hist[i] = i+1 bits ago).
  function automatic logic prbs31_predict(input logic [PRBS31_LEN-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc && (cnt_q != MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
      sat_d = sat_q | (cnt_d == MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 checker: seeds its history from the stream, verifies
// the prediction, then free-runs while locked and counts bit errors.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int ERR_W     = 16,
  parameter int LOCK_GOOD = 32,
  parameter int LOSS_WIN  = 64,
  parameter int LOSS_ERR  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sat
);

  localparam int SEED_W = $clog2(PRBS31_LEN + 1);
  localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int WIN_W  = $clog2(LOSS_WIN);
  localparam int WERR_W = $clog2(LOSS_ERR + 1);

  state_e                  state_q, state_d;
  logic [PRBS31_LEN-1:0]   hist_q, hist_d;
  logic [SEED_W-1:0]       seed_cnt_q, seed_cnt_d;
  logic [GOOD_W-1:0]       good_cnt_q, good_cnt_d;
  logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]       win_err_q, win_err_d;
  logic                    locked_q, locked_d;
  logic                    err_pulse_q, err_pulse_d;

  logic exp_bit;
  logic mismatch;
  logic err_inc;
  logic loss;

  assign exp_bit  = prbs31_predict(hist_q);
  assign mismatch = bit_in ^ exp_bit;
  assign err_inc  = bit_vld && (state_q == LOCKED) && mismatch;
  assign loss     = err_inc && (win_err_q == WERR_W'(LOSS_ERR - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      good_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      good_cnt_q  <= good_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Next-state logic; the nonzero-history check keeps an all-zero stream from locking.
  always_comb begin
    state_d = state_q;
    if (bit_vld) begin
      case (state_q)
        SEED: begin
          if (seed_cnt_q == SEED_W'(PRBS31_LEN - 1)) state_d = VERIFY;
        end
        VERIFY: begin
          if (!mismatch && (good_cnt_d == GOOD_W'(LOCK_GOOD)) && (hist_d != '0)) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (loss) state_d = SEED;
        end
        default: state_d = SEED;
      endcase
    end
  end

  // Datapath and output logic
  always_comb begin
    hist_d     = hist_q;
    seed_cnt_d = seed_cnt_q;
    good_cnt_d = good_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    if (bit_vld) begin
      case (state_q)
        SEED: begin
          hist_d     = {hist_q[PRBS31_LEN-2:0], bit_in};
          seed_cnt_d = (seed_cnt_q == SEED_W'(PRBS31_LEN - 1)) ? '0 : seed_cnt_q + 1'b1;
          good_cnt_d = '0;
        end
        VERIFY: begin
          hist_d = {hist_q[PRBS31_LEN-2:0], bit_in};
          if (mismatch) begin
            good_cnt_d = '0;
          end else if (good_cnt_q != GOOD_W'(LOCK_GOOD)) begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a single flipped bit is a single error.
          if (loss) begin
            hist_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q == WIN_W'(LOSS_WIN - 1)) begin
            hist_d    = {hist_q[PRBS31_LEN-2:0], exp_bit};
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            hist_d    = {hist_q[PRBS31_LEN-2:0], exp_bit};
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + WERR_W'(mismatch);
          end
        end
        default: ;
      endcase
    end
    if (clr) begin
      win_cnt_d = '0;
      win_err_d = '0;
    end
    locked_d    = (state_d == LOCKED);
    err_pulse_d = err_inc;
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (clr),
    .cnt   (err_cnt),
    .sat   (err_sat)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: two instances (16-bit and 4-bit error
// counters) share one stimulus stream driven from a reference PRBS31 generator.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_vld = 1'b0;
  logic        clr = 1'b0;

  logic        locked16, err_pulse16, err_sat16;
  logic [15:0] err_cnt16;
  logic        locked4, err_pulse4, err_sat4;
  logic [3:0]  err_cnt4;

  logic [30:0] lfsr = 31'd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs31_checker #(.ERR_W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .clr       (clr),
    .locked    (locked16),
    .err_pulse (err_pulse16),
    .err_cnt   (err_cnt16),
    .err_sat   (err_sat16)
  );

  prbs31_checker #(.ERR_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .clr       (clr),
    .locked    (locked4),
    .err_pulse (err_pulse4),
    .err_cnt   (err_cnt4),
    .err_sat   (err_sat4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, then return 1 time unit after the active edge.
  task automatic send_raw(input logic b, input logic vld);
    bit_in  = b;
    bit_vld = vld;
    @(posedge clk);
    #1;
  endtask

  // One valid generator bit (optionally inverted) or one gap cycle with junk data.
  task automatic send_gen(input logic flip, input logic vld);
    logic b;
    if (vld) begin
      b    = lfsr[30] ^ flip;
      lfsr = {lfsr[29:0], lfsr[27] ^ lfsr[30]};
      send_raw(b, 1'b1);
    end else begin
      send_raw(~lfsr[30], 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    send_raw(1'b0, 1'b0);
    rst_n = 1'b1;
    lfsr  = 31'd1;
  endtask

  initial begin
    int drops;
    int ever_locked;
    int hold_viol;
    logic lk_before;

    // Reset state
    #3;
    check("rst_locked16", {31'b0, locked16}, 32'd0);
    check("rst_pulse16", {31'b0, err_pulse16}, 32'd0);
    check("rst_cnt16", {16'b0, err_cnt16}, 32'd0);
    check("rst_sat16", {31'b0, err_sat16}, 32'd0);
    check("rst_locked4", {31'b0, locked4}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lfsr  = 31'd1;

    // 1: clean lock exactly after 63 valid bits, then 10,000 clean bits
    for (int i = 0; i < 62; i++) send_gen(1'b0, 1'b1);
    check("t1_not_locked_62", {31'b0, locked16}, 32'd0);
    send_gen(1'b0, 1'b1);
    check("t1_locked_63", {31'b0, locked16}, 32'd1);
    check("t1_locked4_63", {31'b0, locked4}, 32'd1);
    drops = 0;
    for (int i = 63; i < 10000; i++) begin
      send_gen(1'b0, 1'b1);
      if (locked16 !== 1'b1 || err_pulse16 !== 1'b0) drops++;
    end
    check("t1_no_drops", drops, 32'd0);
    check("t1_cnt_clean", {16'b0, err_cnt16}, 32'd0);
    $display("t1 clean lock: locked=%0b err_cnt=%0d", locked16, err_cnt16);

    // 2: single bit error
    send_gen(1'b1, 1'b1);
    check("t2_pulse_hi", {31'b0, err_pulse16}, 32'd1);
    check("t2_cnt1", {16'b0, err_cnt16}, 32'd1);
    check("t2_locked", {31'b0, locked16}, 32'd1);
    send_gen(1'b0, 1'b1);
    check("t2_pulse_lo", {31'b0, err_pulse16}, 32'd0);
    check("t2_cnt1_hold", {16'b0, err_cnt16}, 32'd1);
    $display("t2 single error: err_cnt=%0d locked=%0b", err_cnt16, locked16);

    // 3: loss of lock after 8 errors in one window, then relock
    clr = 1'b1;
    send_gen(1'b0, 1'b1);
    clr = 1'b0;
    check("t3_clr", {16'b0, err_cnt16}, 32'd0);
    for (int i = 0; i < 7; i++) send_gen(1'b1, 1'b1);
    check("t3_locked_7", {31'b0, locked16}, 32'd1);
    check("t3_cnt7", {16'b0, err_cnt16}, 32'd7);
    send_gen(1'b1, 1'b1);
    check("t3_unlocked_8", {31'b0, locked16}, 32'd0);
    check("t3_cnt8", {16'b0, err_cnt16}, 32'd8);
    for (int i = 0; i < 62; i++) send_gen(1'b0, 1'b1);
    check("t3_not_relocked_62", {31'b0, locked16}, 32'd0);
    send_gen(1'b0, 1'b1);
    check("t3_relocked_63", {31'b0, locked16}, 32'd1);
    check("t3_cnt8_kept", {16'b0, err_cnt16}, 32'd8);
    $display("t3 loss/relock: err_cnt=%0d locked=%0b", err_cnt16, locked16);

    // 4: all-zero stream never locks
    do_reset();
    ever_locked = 0;
    for (int i = 0; i < 1000; i++) begin
      send_raw(1'b0, 1'b1);
      if (locked16 !== 1'b0) ever_locked++;
    end
    check("t4_never_locked", ever_locked, 32'd0);
    check("t4_cnt0", {16'b0, err_cnt16}, 32'd0);
    $display("t4 zero stream: locked_cycles=%0d", ever_locked);

    // 5: gapped valid, junk data on gap cycles must be ignored
    do_reset();
    hold_viol = 0;
    for (int i = 0; i < 62; i++) begin
      send_gen(1'b0, 1'b1);
      lk_before = locked16;
      send_gen(1'b0, 1'b0);
      if (locked16 !== lk_before || err_pulse16 !== 1'b0) hold_viol++;
    end
    check("t5_hold", hold_viol, 32'd0);
    check("t5_not_locked_62", {31'b0, locked16}, 32'd0);
    send_gen(1'b0, 1'b1);
    check("t5_locked_63", {31'b0, locked16}, 32'd1);
    send_gen(1'b0, 1'b0);
    check("t5_gap_locked", {31'b0, locked16}, 32'd1);
    send_gen(1'b1, 1'b1);
    check("t5_pulse_hi", {31'b0, err_pulse16}, 32'd1);
    send_gen(1'b0, 1'b0);
    check("t5_gap_pulse_lo", {31'b0, err_pulse16}, 32'd0);
    check("t5_gap_cnt1", {16'b0, err_cnt16}, 32'd1);
    $display("t5 gapped: locked=%0b err_cnt=%0d", locked16, err_cnt16);

    // 6: saturation, clr beating a same-cycle mismatch, async reset
    clr = 1'b1;
    send_gen(1'b0, 1'b1);
    clr = 1'b0;
    for (int e = 0; e < 20; e++) begin
      for (int i = 0; i < 99; i++) send_gen(1'b0, 1'b1);
      send_gen(1'b1, 1'b1);
    end
    check("t6_cnt4_sat", {28'b0, err_cnt4}, 32'd15);
    check("t6_sat4", {31'b0, err_sat4}, 32'd1);
    check("t6_cnt16_20", {16'b0, err_cnt16}, 32'd20);
    check("t6_sat16", {31'b0, err_sat16}, 32'd0);
    check("t6_locked", {31'b0, locked4}, 32'd1);
    clr = 1'b1;
    send_gen(1'b1, 1'b1);
    clr = 1'b0;
    check("t6_clr_cnt4", {28'b0, err_cnt4}, 32'd0);
    check("t6_clr_sat4", {31'b0, err_sat4}, 32'd0);
    check("t6_clr_cnt16", {16'b0, err_cnt16}, 32'd0);
    check("t6_clr_locked", {31'b0, locked4}, 32'd1);
    check("t6_clr_pulse", {31'b0, err_pulse4}, 32'd1);
    send_gen(1'b1, 1'b1);
    check("t6_cnt_after_clr", {28'b0, err_cnt4}, 32'd1);
    check("t6_pulse_pre_rst", {31'b0, err_pulse4}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_locked", {31'b0, locked4}, 32'd0);
    check("t6_rst_pulse", {31'b0, err_pulse4}, 32'd0);
    check("t6_rst_cnt", {28'b0, err_cnt4}, 32'd0);
    check("t6_rst_locked16", {31'b0, locked16}, 32'd0);
    $display("t6 saturation/clear/reset: err_cnt4=%0d locked=%0b", err_cnt4, locked4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
